// File: rtl/cp0_regfile.sv
// CP0 register file: exception/ERET commit, MTC0/MFC0, Count/Compare timer, interrupt pending.
// Optional timer is built only when CP0_TIMER_EN is defined; otherwise Count/Compare read 0.
module cp0_regfile #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_waddr_i,
    input  logic [31:0] cp0_wdata_i,
    input  logic [4:0]  cp0_raddr_i,
    output logic [31:0] cp0_rdata_o,
    input  logic        exc_flag_i,
    input  logic [3:0]  exc_type_i,
    input  logic [31:0] exc_pc_i,
    input  logic        exc_in_delay_i,
    input  logic [31:0] exc_baddr_i,
    input  logic [5:0]  int_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [7:0]  intr_o,
    output logic [31:0] flush_pc_o
);

    localparam logic [3:0] EXC_INTR  = 4'd0;
    localparam logic [3:0] EXC_ADEL1 = 4'd1;
    localparam logic [3:0] EXC_ADEL2 = 4'd2;
    localparam logic [3:0] EXC_ADES  = 4'd3;
    localparam logic [3:0] EXC_OV    = 4'd4;
    localparam logic [3:0] EXC_SYSC  = 4'd5;
    localparam logic [3:0] EXC_BP    = 4'd6;
    localparam logic [3:0] EXC_RI    = 4'd7;
    localparam logic [3:0] EXC_ERET  = 4'd8;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    function automatic logic [4:0] exc_code(input logic [3:0] t);
        logic [4:0] c;
        case (t)
            EXC_INTR:             c = 5'd0;
            EXC_ADEL1, EXC_ADEL2: c = 5'd4;
            EXC_ADES:             c = 5'd5;
            EXC_SYSC:             c = 5'd8;
            EXC_BP:               c = 5'd9;
            EXC_RI:               c = 5'd10;
            EXC_OV:               c = 5'd12;
            default:              c = 5'd0;
        endcase
        return c;
    endfunction

    logic [31:0] status_q, status_d, cause_q, cause_d, epc_q, epc_d, badvaddr_q, badvaddr_d;
    logic [31:0] count_s, compare_s;
    logic        ti_s, timer_hit_s, ti_clr_s, mtc0_s, is_addr_err_s;

    // An exception or ERET in the same cycle squashes the MTC0 completely
    assign mtc0_s = cp0_we_i & ~exc_flag_i;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        div_q, div_d, div_wrap_s;

    // Timer next state: divided Count increment, MTC0 Count/Compare override
    always_comb begin
        div_wrap_s = (COUNT_DIV == 1) || div_q;
        div_d      = div_wrap_s ? 1'b0 : 1'b1;
        count_d    = count_q + {31'd0, div_wrap_s};
        compare_d  = compare_q;
        if (mtc0_s && (cp0_waddr_i == REG_COUNT)) begin
            count_d = cp0_wdata_i;
            div_d   = 1'b0;
        end else if (mtc0_s && (cp0_waddr_i == REG_COMPARE)) begin
            compare_d = cp0_wdata_i;
        end else begin
            compare_d = compare_q;
        end
    end

    // Timer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            div_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            div_q     <= div_d;
        end
    end

    assign count_s     = count_q;
    assign compare_s   = compare_q;
    assign ti_s        = cause_q[30];
    assign timer_hit_s = (count_q == compare_q);
    assign ti_clr_s    = mtc0_s && (cp0_waddr_i == REG_COMPARE);
`else
    assign count_s     = 32'd0;
    assign compare_s   = 32'd0;
    assign ti_s        = 1'b0;
    assign timer_hit_s = 1'b0;
    assign ti_clr_s    = 1'b0;
`endif

    assign is_addr_err_s = (exc_type_i == EXC_ADEL1) || (exc_type_i == EXC_ADEL2) ||
                           (exc_type_i == EXC_ADES);

    // Next state of Status/Cause/EPC/BadVAddr; exception commit has priority over MTC0
    always_comb begin
        status_d          = status_q;
        cause_d           = cause_q;
        epc_d             = epc_q;
        badvaddr_d        = badvaddr_q;
        cause_d[15:10]    = {int_i[5] | ti_s, int_i[4:0]};
        cause_d[30]       = ti_clr_s ? 1'b0 : (timer_hit_s | cause_q[30]);
        if (exc_flag_i) begin
            if (exc_type_i == EXC_ERET) begin
                status_d[1] = 1'b0;
            end else begin
                // Nested exceptions (EXL already set) keep the original EPC and BD
                epc_d       = status_q[1] ? epc_q :
                              (exc_in_delay_i ? exc_pc_i - 32'd4 : exc_pc_i);
                cause_d[31] = status_q[1] ? cause_q[31] : exc_in_delay_i;
                cause_d[6:2] = exc_code(exc_type_i);
                status_d[1] = 1'b1;
                badvaddr_d  = is_addr_err_s ? exc_baddr_i : badvaddr_q;
            end
        end else if (mtc0_s) begin
            case (cp0_waddr_i)
                REG_STATUS: status_d    = (status_q & ~STATUS_WMASK) | (cp0_wdata_i & STATUS_WMASK);
                REG_CAUSE:  cause_d[9:8] = cp0_wdata_i[9:8];
                REG_EPC:    epc_d       = cp0_wdata_i;
                default:    epc_d       = epc_q;
            endcase
        end else begin
            status_d = status_q;
        end
    end

    // Architectural register state
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_RST;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    // MFC0 read mux, no same-cycle bypass
    always_comb begin
        case (cp0_raddr_i)
            REG_BADVADDR: cp0_rdata_o = badvaddr_q;
            REG_COUNT:    cp0_rdata_o = count_s;
            REG_COMPARE:  cp0_rdata_o = compare_s;
            REG_STATUS:   cp0_rdata_o = status_q;
            REG_CAUSE:    cp0_rdata_o = cause_q;
            REG_EPC:      cp0_rdata_o = epc_q;
            default:      cp0_rdata_o = 32'd0;
        endcase
    end

    assign status_o   = status_q;
    assign cause_o    = cause_q;
    assign epc_o      = epc_q;
    assign intr_o     = cause_q[15:8] & status_q[15:8] & {8{status_q[0] & ~status_q[1]}};
    assign flush_pc_o = (exc_type_i == EXC_ERET) ? epc_q : EXC_VECTOR;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile; timer checks follow the CP0_TIMER_EN build.
module tb_cp0_regfile;

    localparam logic [3:0] T_INTR = 4'd0, T_ADEL2 = 4'd2, T_OV = 4'd4, T_SYSC = 4'd5, T_ERET = 4'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cp0_we_i;
    logic [4:0]  cp0_waddr_i, cp0_raddr_i;
    logic [31:0] cp0_wdata_i, cp0_rdata_o;
    logic        exc_flag_i, exc_in_delay_i;
    logic [3:0]  exc_type_i;
    logic [31:0] exc_pc_i, exc_baddr_i;
    logic [5:0]  int_i;
    logic [31:0] status_o, cause_o, epc_o, flush_pc_o;
    logic [7:0]  intr_o;

    int checks_cnt = 0;
    int errors_cnt = 0;

    cp0_regfile dut (
        .clk(clk), .rst(rst),
        .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
        .cp0_raddr_i(cp0_raddr_i), .cp0_rdata_o(cp0_rdata_o),
        .exc_flag_i(exc_flag_i), .exc_type_i(exc_type_i), .exc_pc_i(exc_pc_i),
        .exc_in_delay_i(exc_in_delay_i), .exc_baddr_i(exc_baddr_i), .int_i(int_i),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
        .intr_o(intr_o), .flush_pc_o(flush_pc_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] addr, input string tag, input logic [31:0] exp);
        cp0_raddr_i = addr;
        #1;
        check_eq(tag, cp0_rdata_o, exp);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        cp0_we_i    = 1'b1;
        cp0_waddr_i = addr;
        cp0_wdata_i = data;
        tick();
        cp0_we_i    = 1'b0;
    endtask

    task automatic raise(input logic [3:0] t, input logic [31:0] pc, input logic dly,
                         input logic [31:0] baddr);
        exc_flag_i     = 1'b1;
        exc_type_i     = t;
        exc_pc_i       = pc;
        exc_in_delay_i = dly;
        exc_baddr_i    = baddr;
        tick();
        exc_flag_i     = 1'b0;
        exc_type_i     = T_INTR;
    endtask

    initial begin
        rst = 1'b1; cp0_we_i = 1'b0; cp0_waddr_i = 5'd0; cp0_wdata_i = 32'd0;
        cp0_raddr_i = 5'd0; exc_flag_i = 1'b0; exc_type_i = T_INTR; exc_pc_i = 32'd0;
        exc_in_delay_i = 1'b0; exc_baddr_i = 32'd0; int_i = 6'd0;
        tick(); tick();
        rst = 1'b0;

        // reset state
        rd(5'd12, "rst_status", 32'h0040_0000);
        rd(5'd13, "rst_cause", 32'd0);
        rd(5'd14, "rst_epc", 32'd0);
        check_eq("rst_intr", {24'd0, intr_o}, 32'd0);
        check_eq("rst_flush", flush_pc_o, 32'hBFC0_0380);

        // park Compare far away so the timer stays quiet until the timer test
        mtc0(5'd11, 32'hFFFF_FFFF);

        // overflow in a delay slot
        raise(T_OV, 32'hBFC0_1000, 1'b1, 32'd0);
        check_eq("ov_epc", epc_o, 32'hBFC0_0FFC);
        check_eq("ov_cause", cause_o, 32'h8000_0030);
        check_eq("ov_status", status_o, 32'h0040_0002);

        // nested AdEL2 keeps EPC/BD, then ERET
        raise(T_ADEL2, 32'h0000_1234, 1'b0, 32'h0000_0003);
        check_eq("adel_epc", epc_o, 32'hBFC0_0FFC);
        rd(5'd8, "adel_badvaddr", 32'h0000_0003);
        check_eq("adel_cause", cause_o, 32'h8000_0010);
        exc_flag_i = 1'b1; exc_type_i = T_ERET;
        #1;
        check_eq("eret_flush", flush_pc_o, 32'hBFC0_0FFC);
        tick();
        exc_flag_i = 1'b0; exc_type_i = T_INTR;
        #1;
        check_eq("eret_status", status_o, 32'h0040_0000);
        check_eq("eret_epc", epc_o, 32'hBFC0_0FFC);
        check_eq("flush_vector", flush_pc_o, 32'hBFC0_0380);

        // hardware interrupt with IM2/IE, one-cycle latency, masked by EXL
        mtc0(5'd12, 32'h0000_0401);
        check_eq("im_status", status_o, 32'h0040_0401);
        check_eq("int_idle", {24'd0, intr_o}, 32'd0);
        int_i = 6'b000001;
        #1;
        check_eq("int_latency", {24'd0, intr_o}, 32'd0);
        tick();
        check_eq("int_pending", {24'd0, intr_o}, 32'h0000_0004);
        mtc0(5'd12, 32'h0000_0403);
        check_eq("int_exl_mask", {24'd0, intr_o}, 32'd0);
        int_i = 6'd0;

        // Cause only IP1:0 writable; BadVAddr read-only; unimplemented reads 0
        mtc0(5'd13, 32'hFFFF_FFFF);
        check_eq("cause_wmask", cause_o, 32'h8000_0310);
        mtc0(5'd8, 32'h0000_DEAD);
        rd(5'd8, "badvaddr_ro", 32'h0000_0003);
        rd(5'd3, "unimpl_reg", 32'd0);

        // MTC0 EPC squashed by a simultaneous SysC
        mtc0(5'd12, 32'h0000_0000);
        cp0_we_i = 1'b1; cp0_waddr_i = 5'd14; cp0_wdata_i = 32'hDEAD_BEEF;
        raise(T_SYSC, 32'h0000_0100, 1'b0, 32'h0000_0000);
        cp0_we_i = 1'b0;
        check_eq("sysc_epc", epc_o, 32'h0000_0100);
        check_eq("sysc_cause", cause_o, 32'h0000_0320);

        // Count/Compare timer
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        for (int i = 0; i < 9; i++) tick();
`ifdef CP0_TIMER_EN
        rd(5'd9, "count_9clk", 32'd4);
        tick();
        rd(5'd9, "count_10clk", 32'd5);
        rd(5'd11, "compare_rd", 32'd5);
        check_eq("ti_before", {31'd0, cause_o[30]}, 32'd0);
        tick();
        check_eq("ti_set", {31'd0, cause_o[30]}, 32'd1);
        check_eq("ip7_before", {24'd0, intr_o}, 32'd0);
        tick();
        check_eq("timer_intr", {24'd0, intr_o}, 32'h0000_0080);
        mtc0(5'd11, 32'h0000_1000);
        check_eq("ti_clear", {31'd0, cause_o[30]}, 32'd0);
        mtc0(5'd9, 32'hFFFF_FFFF);
        tick(); tick();
        rd(5'd9, "count_wrap", 32'd0);
`else
        rd(5'd9, "count_off", 32'd0);
        tick();
        rd(5'd11, "compare_off", 32'd0);
        tick(); tick();
        check_eq("ti_off", {31'd0, cause_o[30]}, 32'd0);
        check_eq("timer_intr_off", {24'd0, intr_o}, 32'd0);
`endif

        // synchronous reset mid-operation, inputs active
        rst = 1'b1; int_i = 6'h3F; cp0_we_i = 1'b1; cp0_waddr_i = 5'd14; cp0_wdata_i = 32'h1;
        tick();
        rst = 1'b0; cp0_we_i = 1'b0; int_i = 6'd0;
        check_eq("mid_rst_status", status_o, 32'h0040_0000);
        check_eq("mid_rst_cause", cause_o, 32'd0);
        check_eq("mid_rst_epc", epc_o, 32'd0);
        rd(5'd8, "mid_rst_badvaddr", 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
